// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests and buffers returned words.
// Optional FETCH_MISALIGN_EN adds id_misalign and a trap-style packet for misaligned redirect targets.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
`ifdef FETCH_MISALIGN_EN
  output logic        id_misalign,
`endif
  output logic [31:0] id_pc4
);

  localparam int          PW  = $clog2(BUF_DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, kill_q, kill_d, i_cnt_q, i_cnt_d;
  logic [PW-1:0] a_wr_q, a_wr_d, a_rd_q, a_rd_d, i_wr_q, i_wr_d, i_rd_q, i_rd_d;

  logic [31:0] addr_mem  [BUF_DEPTH];
  logic [31:0] ipc_mem   [BUF_DEPTH];
  logic [31:0] iinst_mem [BUF_DEPTH];

  logic        head_valid, pop, grant, resp, keep, halted, mis_out;
  logic [CW:0] occ;
  logic [31:0] redir_pc;

`ifdef FETCH_MISALIGN_EN
  logic        halt_q, halt_d, mis_pend_q, mis_pend_d;
  logic [31:0] mis_pc_q, mis_pc_d;
`endif

  always_comb begin
    head_valid = (i_cnt_q != '0);
`ifdef FETCH_MISALIGN_EN
    redir_pc = redirect_pc;
    halted   = halt_q;
    mis_out  = mis_pend_q && (out_q == '0);
`else
    redir_pc = redirect_pc & 32'hFFFF_FFFC;
    halted   = 1'b0;
    mis_out  = 1'b0;
`endif
    pop = head_valid && !id_stall && !redirect;
    // The slot freed by a same-cycle pop counts as credit, giving 1 instr/cycle at depth 2.
    occ = {1'b0, out_q} + {1'b0, i_cnt_q} - (CW+1)'(pop);
    imem_req = !rst && !redirect && !halted && (occ < (CW+1)'(BUF_DEPTH));
    grant = imem_req && imem_gnt;
    resp  = imem_rvalid && (out_q != '0);
    keep  = resp && (kill_q == '0) && !redirect;

    pc_d   = redirect ? redir_pc : (grant ? pc_q + 32'd4 : pc_q);
    a_wr_d = a_wr_q + PW'(grant);
    a_rd_d = a_rd_q + PW'(resp);
    out_d  = out_q + CW'(grant) - CW'(resp);

    // Every response still in flight at a redirect is wrong-path; kill never exceeds outstanding.
    if (redirect)
      kill_d = out_q - CW'(resp);
    else if (resp && (kill_q != '0))
      kill_d = kill_q - CW'(1);
    else
      kill_d = kill_q;

    if (redirect) begin
      i_wr_d  = '0;
      i_rd_d  = '0;
      i_cnt_d = '0;
    end else begin
      i_wr_d  = i_wr_q + PW'(keep);
      i_rd_d  = i_rd_q + PW'(pop);
      i_cnt_d = i_cnt_q + CW'(keep) - CW'(pop);
    end

    id_valid = !rst && (head_valid || mis_out);
    id_inst  = NOP;
    id_pc    = 32'd0;
    if (!rst && head_valid) begin
      id_inst = iinst_mem[i_rd_q];
      id_pc   = ipc_mem[i_rd_q];
    end else if (!rst && mis_out) begin
      id_pc = redir_pc_hold();
    end
    id_pc4 = id_pc + 32'd4;
  end

  function automatic logic [31:0] redir_pc_hold();
`ifdef FETCH_MISALIGN_EN
    return mis_pc_q;
`else
    return 32'd0;
`endif
  endfunction

  assign imem_addr = pc_q;

`ifdef FETCH_MISALIGN_EN
  always_comb begin
    halt_d     = halt_q;
    mis_pend_d = mis_pend_q;
    mis_pc_d   = mis_pc_q;
    if (redirect) begin
      halt_d     = (redirect_pc[1:0] != 2'b00);
      mis_pend_d = (redirect_pc[1:0] != 2'b00);
      mis_pc_d   = redirect_pc;
    end else if (mis_out && !id_stall) begin
      mis_pend_d = 1'b0;
    end
  end

  assign id_misalign = !rst && mis_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q     <= 1'b0;
      mis_pend_q <= 1'b0;
      mis_pc_q   <= 32'd0;
    end else begin
      halt_q     <= halt_d;
      mis_pend_q <= mis_pend_d;
      mis_pc_q   <= mis_pc_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      out_q   <= '0;
      kill_q  <= '0;
      i_cnt_q <= '0;
      a_wr_q  <= '0;
      a_rd_q  <= '0;
      i_wr_q  <= '0;
      i_rd_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      out_q   <= out_d;
      kill_q  <= kill_d;
      i_cnt_q <= i_cnt_d;
      a_wr_q  <= a_wr_d;
      a_rd_q  <= a_rd_d;
      i_wr_q  <= i_wr_d;
      i_rd_q  <= i_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) addr_mem[a_wr_q] <= pc_q;
    if (keep) begin
      ipc_mem[i_wr_q]   <= addr_mem[a_rd_q];
      iinst_mem[i_wr_q] <= imem_rdata;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) assert (!(imem_rvalid && (out_q == '0)));
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model plus a queue/epoch reference of the packet stream.
module tb_fetch_stage;
  localparam int          D   = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_gnt, imem_rvalid, redirect, id_stall, id_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_inst, id_pc, id_pc4;
`ifdef FETCH_MISALIGN_EN
  logic        id_misalign;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_stall(id_stall), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc),
`ifdef FETCH_MISALIGN_EN
    .id_misalign(id_misalign),
`endif
    .id_pc4(id_pc4)
  );

  typedef struct { logic [31:0] addr; int ep; int rdy; } ent_t;
  ent_t        mq[$];
  logic [31:0] oq_pc[$];
  logic [31:0] oq_inst[$];

  int checks = 0, errors = 0, cyc = 0, epoch = 0;
  logic [31:0] exp_pc;
  bit          halted = 0, mis_pend = 0;
  logic [31:0] mis_pc = 0;

  int gnt_pct, rv_pct, lat_min, lat_max;
  bit d_redirect, d_stall;
  logic [31:0] d_rpc;
  bit o_valid, o_req, o_grant, o_mis;
  logic [31:0] o_pc, o_pc4, o_inst, o_addr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare 1ns later, advance the model at posedge, return at negedge.
  task automatic cycle();
    int n_out;
    bit rv, pop_e, exp_req, mis_vis;
    ent_t resp;
    logic [31:0] e_pc, e_inst;
    n_out = mq.size();
    rv = 0;
    resp = '{addr: 32'd0, ep: -1, rdy: 0};
    if (mq.size() > 0 && mq[0].rdy <= cyc && $urandom_range(99) < rv_pct) begin
      rv = 1;
      resp = mq.pop_front();
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(resp.addr) : $urandom;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    redirect    = d_redirect;
    redirect_pc = d_rpc;
    id_stall    = d_stall;
    #1;
    mis_vis = mis_pend && (n_out == 0);
    pop_e   = (oq_pc.size() > 0) && !d_stall && !d_redirect;
    exp_req = !d_redirect && !halted && ((n_out + oq_pc.size() - int'(pop_e)) < D);
    e_pc    = (oq_pc.size() > 0) ? oq_pc[0] : (mis_vis ? mis_pc : 32'd0);
    e_inst  = (oq_pc.size() > 0) ? oq_inst[0] : NOP;
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, exp_pc);
    chk("id_valid", id_valid, (oq_pc.size() > 0) || mis_vis);
    chk("id_inst", id_inst, e_inst);
    chk("id_pc", id_pc, e_pc);
    chk("id_pc4", id_pc4, e_pc + 32'd4);
`ifdef FETCH_MISALIGN_EN
    chk("id_misalign", id_misalign, mis_vis);
    o_mis = id_misalign;
`else
    o_mis = 0;
`endif
    o_valid = id_valid; o_pc = id_pc; o_pc4 = id_pc4; o_inst = id_inst;
    o_req = imem_req; o_addr = imem_addr;
    o_grant = imem_req && imem_gnt;
    if (o_grant) mq.push_back('{addr: exp_pc, ep: epoch, rdy: cyc + $urandom_range(lat_max, lat_min)});
    @(posedge clk);
    if (d_redirect) begin
      oq_pc.delete();
      oq_inst.delete();
      epoch++;
`ifdef FETCH_MISALIGN_EN
      exp_pc   = d_rpc;
      halted   = (d_rpc[1:0] != 2'b00);
      mis_pend = halted;
      mis_pc   = d_rpc;
`else
      exp_pc = {d_rpc[31:2], 2'b00};
`endif
    end else begin
      if (pop_e) begin
        void'(oq_pc.pop_front());
        void'(oq_inst.pop_front());
      end
      if (mis_vis && !d_stall) mis_pend = 0;
      if (rv && resp.ep == epoch) begin
        oq_pc.push_back(resp.addr);
        oq_inst.push_back(mem_word(resp.addr));
      end
      if (o_grant) exp_pc = exp_pc + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_mem(int g, int r, int lmin, int lmax);
    gnt_pct = g; rv_pct = r; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic do_redirect(logic [31:0] target);
    d_redirect = 1; d_rpc = target;
    cycle();
    d_redirect = 0;
  endtask

  // Runs until a valid packet is seen (bounded); returns its pc and how many cycles it took.
  task automatic wait_valid(string name, output logic [31:0] pc, output int n);
    pc = 32'hDEAD_BEEF;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      n++;
      if (o_valid) begin
        pc = o_pc;
        return;
      end
    end
    chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  bit          v_log[16];
  logic [31:0] pc_log[16];

  initial begin
    logic [31:0] held, dropped, pc;
    int n, seen, grants;
    bit found;

    rst = 1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; id_stall = 0;
    d_redirect = 0; d_stall = 0; d_rpc = 0; exp_pc = 32'h0;
    set_mem(100, 100, 1, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_id_valid", id_valid, 1'b0);
      chk("rst_id_inst", id_inst, NOP);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_id_pc4", id_pc4, 32'd4);
      if (k > 0) chk("rst_imem_addr", imem_addr, 32'h0);
    end
    rst = 0;

    // Zero-wait memory: first packet two cycles after reset, then one per cycle.
    for (int k = 0; k < 10; k++) begin
      cycle();
      v_log[k] = o_valid;
      pc_log[k] = o_pc;
      if (k == 0) chk("first_req_addr", o_addr, 32'h0);
    end
    chk("zw_bubble_c1", v_log[1], 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("zw_valid_seq", v_log[2+k], 1'b1);
      chk("zw_pc_seq", pc_log[2+k], 32'(4 * k));
    end
    $display("txn zero-wait: first packets pc=%h %h %h %h", pc_log[2], pc_log[3], pc_log[4], pc_log[5]);

    // Decode stall for 5 cycles: head frozen, buffer full so no requests.
    d_stall = 1;
    grants = 0;
    held = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (k == 0) held = o_pc;
      chk("stall_head_stable", o_pc, held);
      grants += int'(o_grant);
    end
    chk("stall_grants", grants, 0);
    d_stall = 0;
    for (int k = 0; k < 6; k++) cycle();
    $display("txn stall: held pc=%h grants=%0d", held, grants);

    // Latency 3 with two outstanding, redirect to 0x100.
    set_mem(100, 100, 3, 3);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mq.size() == D) found = 1; else cycle();
    end
    chk("lat3_two_outstanding", found, 1'b1);
    do_redirect(32'h0000_0100);
    cycle();
    chk("redir_next_valid", o_valid, 1'b0);
    wait_valid("redir100", pc, n);
    chk("redir100_pc", pc, 32'h0000_0100);
    chk("redir100_latency", (n + 1 >= 3), 1'b1);
    $display("txn redirect 0x100: first pc=%h after %0d cycles", pc, n + 1);

    // Redirect colliding with a response: that response must never surface.
    set_mem(100, 100, 1, 1);
    for (int k = 0; k < 4; k++) cycle();
    found = (mq.size() > 0 && mq[0].rdy <= cyc);
    chk("collide_setup", found, 1'b1);
    dropped = found ? mq[0].addr : 32'hFFFF_FFF0;
    do_redirect(32'h0000_0300);
    chk("collide_rvalid_seen", imem_rvalid, 1'b1);
    cycle();
    chk("collide_next_valid", o_valid, 1'b0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (o_valid && o_pc == dropped) seen++;
    end
    chk("collide_dropped_absent", seen, 0);
    $display("txn redirect+rvalid: dropped pc=%h seen=%0d", dropped, seen);

    // PC wrap.
    do_redirect(32'hFFFF_FFF8);
    found = 0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (o_valid && found && n == 0) begin
        chk("wrap_next_pc", o_pc, 32'h0);
        n = 1;
      end
      if (o_valid && o_pc == 32'hFFFF_FFFC) begin
        chk("wrap_pc4", o_pc4, 32'h0);
        found = 1;
      end
    end
    chk("wrap_seen", {found, n[0]}, 2'b11);
    $display("txn wrap: seen=%0d next=%0d", found, n);

`ifdef FETCH_MISALIGN_EN
    do_redirect(32'h0000_0102);
    chk("mis_no_req", o_req, 1'b0);
    wait_valid("mis", pc, n);
    chk("mis_pc", pc, 32'h0000_0102);
    chk("mis_flag", o_mis, 1'b1);
    chk("mis_inst", o_inst, NOP);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      seen += int'(o_req) + int'(o_valid);
    end
    chk("mis_idle", seen, 0);
    do_redirect(32'h0000_0200);
    wait_valid("mis_resume", pc, n);
    chk("mis_resume_pc", pc, 32'h0000_0200);
    $display("txn misalign: packet pc=0x102, resumed pc=%h", pc);
`else
    do_redirect(32'h0000_0102);
    wait_valid("force_align", pc, n);
    chk("force_align_pc", pc, 32'h0000_0100);
    $display("txn redirect 0x102: first pc=%h", pc);
`endif

    // Randomised traffic.
    for (int blk = 0; blk < 30; blk++) begin
      set_mem($urandom_range(100, 40), $urandom_range(100, 40), 1, $urandom_range(4, 1));
      for (int k = 0; k < 100; k++) begin
        d_stall = ($urandom_range(99) < 30);
        if ($urandom_range(99) < 3) begin
`ifdef FETCH_MISALIGN_EN
          d_rpc = $urandom & 32'hFFFF_FFFC;
`else
          d_rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(3)) : $urandom;
`endif
          d_redirect = 1;
        end
        cycle();
        d_redirect = 0;
      end
      $display("txn random block %0d: checks=%0d errors=%0d", blk, checks, errors);
    end
    d_stall = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
